// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the register file: read ports, writeback, issue and flush.
// Master is the pipeline side; slave is the register file.
interface regfile_scoreboard_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] readAddr1;
   logic [ADDR_W-1:0] readAddr2;
   logic [DATA_W-1:0] readData1;
   logic [DATA_W-1:0] readData2;
   logic              readBusy1;
   logic              readBusy2;
   logic              writeEnable;
   logic [ADDR_W-1:0] writeAddr;
   logic [DATA_W-1:0] writeData;
   logic              issueEnable;
   logic [ADDR_W-1:0] issueAddr;
   logic              flush;

   modport master (
      output readAddr1, readAddr2, writeEnable, writeAddr, writeData,
             issueEnable, issueAddr, flush,
      input  readData1, readData2, readBusy1, readBusy2
   );

   modport slave (
      input  readAddr1, readAddr2, writeEnable, writeAddr, writeData,
             issueEnable, issueAddr, flush,
      output readData1, readData2, readBusy1, readBusy2
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard and write-to-read bypass; reads are combinational (0 cycles).
// No backpressure: every write, issue and flush is accepted at the rising edge.
module regfile_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input logic               clk,
   input logic               rst,
   regfile_scoreboard_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busyNext;

   logic writeOk, issueOk;
   logic zero1, zero2, fwd1, fwd2;

   // Register 0 swallows writes and issues when hardwired to zero.
   assign writeOk = bus.writeEnable && !(ZERO_REG && (bus.writeAddr == '0));
   assign issueOk = bus.issueEnable && !(ZERO_REG && (bus.issueAddr == '0));

   assign zero1 = ZERO_REG && (bus.readAddr1 == '0);
   assign zero2 = ZERO_REG && (bus.readAddr2 == '0);
   assign fwd1  = BYPASS && !rst && writeOk && (bus.writeAddr == bus.readAddr1);
   assign fwd2  = BYPASS && !rst && writeOk && (bus.writeAddr == bus.readAddr2);

   // Applied lowest priority first so issue wins over flush, and flush over write.
   always_comb begin
      busyNext = busy;
      if (writeOk) busyNext[bus.writeAddr] = 1'b0;
      if (bus.flush) busyNext = '0;
      if (issueOk) busyNext[bus.issueAddr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         if (writeOk) regs[bus.writeAddr] <= bus.writeData;
         busy <= busyNext;
      end
   end

   always_comb begin
      bus.readData1 = regs[bus.readAddr1];
      bus.readBusy1 = busy[bus.readAddr1];
      if (zero1) begin
         bus.readData1 = '0;
         bus.readBusy1 = 1'b0;
      end else if (fwd1) begin
         bus.readData1 = bus.writeData;
         bus.readBusy1 = 1'b0;
      end
   end

   always_comb begin
      bus.readData2 = regs[bus.readAddr2];
      bus.readBusy2 = busy[bus.readAddr2];
      if (zero2) begin
         bus.readData2 = '0;
         bus.readBusy2 = 1'b0;
      end else if (fwd2) begin
         bus.readData2 = bus.writeData;
         bus.readBusy2 = 1'b0;
      end
   end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: four configurations share one directed stimulus stream;
// expectations are queued at drive time and popped by a negedge monitor.
module tb_regfile_scoreboard;
   logic clk;
   logic rst;

   regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
   regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) if1 ();
   regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) if2 ();
   regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(4)) if3 ();

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1))
      dut0 (.clk(clk), .rst(rst), .bus(if0));
   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b1))
      dut1 (.clk(clk), .rst(rst), .bus(if1));
   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0))
      dut2 (.clk(clk), .rst(rst), .bus(if2));
   regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1))
      dut3 (.clk(clk), .rst(rst), .bus(if3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          dut;
      int          port;
      logic [31:0] data;
      logic        busy;
   } exp_t;

   exp_t  expQ[$];
   string nameQ[$];
   int    checks = 0;
   int    errors = 0;

   task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                        input logic fl, input logic [4:0] a1, input logic [4:0] a2);
      rst = r;
      if0.writeEnable = we; if0.writeAddr = wa; if0.writeData = wd;
      if0.issueEnable = ie; if0.issueAddr = ia; if0.flush = fl;
      if0.readAddr1 = a1;   if0.readAddr2 = a2;
      if1.writeEnable = we; if1.writeAddr = wa; if1.writeData = wd;
      if1.issueEnable = ie; if1.issueAddr = ia; if1.flush = fl;
      if1.readAddr1 = a1;   if1.readAddr2 = a2;
      if2.writeEnable = we; if2.writeAddr = wa; if2.writeData = wd;
      if2.issueEnable = ie; if2.issueAddr = ia; if2.flush = fl;
      if2.readAddr1 = a1;   if2.readAddr2 = a2;
      if3.writeEnable = we; if3.writeAddr = wa[3:0]; if3.writeData = wd[15:0];
      if3.issueEnable = ie; if3.issueAddr = ia[3:0]; if3.flush = fl;
      if3.readAddr1 = a1[3:0]; if3.readAddr2 = a2[3:0];
   endtask

   task automatic expOne(input int dut, input int port, input logic [31:0] d,
                         input logic b, input string nm);
      exp_t e;
      e.dut = dut; e.port = port; e.data = d; e.busy = b;
      expQ.push_back(e);
      nameQ.push_back(nm);
   endtask

   task automatic expAll(input int port, input logic [31:0] d32, input logic [15:0] d16,
                         input logic b, input string nm);
      expOne(0, port, d32, b, nm);
      expOne(1, port, d32, b, nm);
      expOne(2, port, d32, b, nm);
      expOne(3, port, {16'h0, d16}, b, nm);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic getOut(input int dut, input int port, output logic [31:0] d, output logic b);
      d = 'x; b = 1'bx;
      case (dut)
         0: begin d = (port == 1) ? if0.readData1 : if0.readData2;
                  b = (port == 1) ? if0.readBusy1 : if0.readBusy2; end
         1: begin d = (port == 1) ? if1.readData1 : if1.readData2;
                  b = (port == 1) ? if1.readBusy1 : if1.readBusy2; end
         2: begin d = (port == 1) ? if2.readData1 : if2.readData2;
                  b = (port == 1) ? if2.readBusy1 : if2.readBusy2; end
         default: begin d = {16'h0, (port == 1) ? if3.readData1 : if3.readData2};
                  b = (port == 1) ? if3.readBusy1 : if3.readBusy2; end
      endcase
   endtask

   exp_t        monE;
   string       monName;
   logic [31:0] monData;
   logic        monBusy;

   always @(negedge clk) begin
      while (expQ.size() > 0) begin
         monE    = expQ.pop_front();
         monName = nameQ.pop_front();
         getOut(monE.dut, monE.port, monData, monBusy);
         checks++;
         if (monData !== monE.data || monBusy !== monE.busy) begin
            errors++;
            $display("FAIL %s dut%0d port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                     monName, monE.dut, monE.port, monData, monBusy, monE.data, monE.busy);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();

      for (int a = 0; a < 32; a++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
         expAll(1, 32'h0, 16'h0, 0, "reset_rd1");
         expAll(2, 32'h0, 16'h0, 0, "reset_rd2");
         tick();
      end

      drive(0, 1, 2, 32'h12345678, 0, 0, 0, 0, 0);
      expOne(0, 1, 32'h0, 0, "x0_during_write");
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 2, 2);
      expAll(1, 32'h12345678, 16'h5678, 0, "write_read_x2");
      tick();

      drive(0, 1, 0, 32'h0000ABCD, 0, 0, 0, 0, 0);
      expOne(0, 1, 32'h0, 0, "zero_reg_bypass");
      expOne(1, 1, 32'h0000ABCD, 0, "nozero_bypass_x0");
      expOne(2, 1, 32'h0, 0, "zero_reg_nobypass");
      expOne(3, 1, 32'h0, 0, "zero_reg_narrow");
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      expOne(0, 1, 32'h0, 0, "zero_reg_after");
      expOne(1, 2, 32'h0000ABCD, 0, "nozero_x0_stored");
      expOne(2, 1, 32'h0, 0, "zero_reg_after_nb");
      expOne(3, 2, 32'h0, 0, "zero_reg_after_narrow");
      tick();

      drive(0, 0, 0, 0, 1, 5, 0, 5, 5);
      expAll(1, 32'h0, 16'h0, 0, "issue_x5_same_cycle");
      tick();
      drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5);
      expOne(0, 1, 32'hDEADBEEF, 0, "bypass_p1");
      expOne(0, 2, 32'hDEADBEEF, 0, "bypass_p2");
      expOne(1, 1, 32'hDEADBEEF, 0, "bypass_p1_nz");
      expOne(3, 2, 32'h0000BEEF, 0, "bypass_p2_narrow");
      expOne(2, 1, 32'h0, 1, "nobypass_old_p1");
      expOne(2, 2, 32'h0, 1, "nobypass_old_p2");
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 5, 5);
      expAll(1, 32'hDEADBEEF, 16'hBEEF, 0, "x5_next_p1");
      expAll(2, 32'hDEADBEEF, 16'hBEEF, 0, "x5_next_p2");
      tick();

      drive(0, 0, 0, 0, 1, 7, 0, 7, 0);
      expAll(1, 32'h0, 16'h0, 0, "issue_x7_not_yet");
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 7, 0);
      expAll(1, 32'h0, 16'h0, 1, "x7_busy");
      tick();
      drive(0, 1, 7, 32'h55, 0, 0, 0, 7, 0);
      expOne(0, 1, 32'h55, 0, "x7_write_bypass");
      expOne(3, 1, 32'h55, 0, "x7_write_bypass_narrow");
      expOne(2, 1, 32'h0, 1, "x7_write_nobypass");
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 7, 0);
      expAll(1, 32'h55, 16'h0055, 0, "x7_written");
      tick();
      drive(0, 1, 7, 32'h99, 1, 7, 0, 7, 0);
      expOne(0, 1, 32'h99, 0, "issue_write_bypass");
      expOne(2, 1, 32'h55, 0, "issue_write_nobypass");
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 7, 7);
      expAll(1, 32'h99, 16'h0099, 1, "issue_write_busy_stays");
      tick();

      drive(0, 1, 3, 32'h33, 1, 3, 0, 0, 0); tick();
      drive(0, 1, 4, 32'h44, 1, 4, 0, 0, 0); tick();
      drive(0, 1, 9, 32'h9A, 1, 9, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 3, 9);
      expAll(1, 32'h33, 16'h0033, 1, "x3_busy_prefl");
      expAll(2, 32'h9A, 16'h009A, 1, "x9_busy_prefl");
      tick();
      drive(0, 0, 0, 0, 1, 10, 1, 4, 10);
      expAll(1, 32'h44, 16'h0044, 1, "flush_cycle_x4");
      expAll(2, 32'h0, 16'h0, 0, "flush_cycle_x10");
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 3, 10);
      expAll(1, 32'h33, 16'h0033, 0, "flushed_x3");
      expAll(2, 32'h0, 16'h0, 1, "flush_issue_x10");
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 4, 9);
      expAll(1, 32'h44, 16'h0044, 0, "flushed_x4");
      expAll(2, 32'h9A, 16'h009A, 0, "flushed_x9");
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 7, 5);
      expAll(1, 32'h99, 16'h0099, 0, "flushed_x7");
      expAll(2, 32'hDEADBEEF, 16'hBEEF, 0, "x5_kept");
      tick();

      drive(0, 1, 1, 32'h11, 1, 1, 0, 0, 0); tick();
      drive(1, 1, 1, 32'h77, 1, 1, 0, 1, 2);
      expAll(1, 32'h11, 16'h0011, 1, "rst_cycle_no_bypass");
      expAll(2, 32'h12345678, 16'h5678, 0, "rst_cycle_old_x2");
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 2);
      expAll(1, 32'h0, 16'h0, 0, "post_rst_x1");
      expAll(2, 32'h0, 16'h0, 0, "post_rst_x2");
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 10, 0);
      expAll(1, 32'h0, 16'h0, 0, "post_rst_x10");
      expAll(2, 32'h0, 16'h0, 0, "post_rst_x0");
      tick();

      repeat (2) @(posedge clk);
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
